sprite_index_writer: RTL and testbench

//  Palette encoder and writer for the sprite index memory. It is the write side of the

---
 rtl/sprite_pkg.sv | 22 ++
 rtl/palette_match.sv | 18 +
 rtl/sprite_index_writer.sv | 122 ++++++++++++
 tb/tb_sprite_index_writer.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_pkg.sv
// Shared sprite palette definitions, used by both the read-side ROM and the index writer.
package sprite_pkg;

  localparam int unsigned PAL_SIZE = 20;
  localparam int unsigned IDX_W    = 5;

  localparam logic [23:0] PAL [PAL_SIZE] = '{
    24'h050505, 24'h000000, 24'hFFFFFF, 24'hFF0000, 24'h00FF00,
    24'h0000FF, 24'hFFFF00, 24'hFF00FF, 24'h00FFFF, 24'h808080,
    24'h553F0B, 24'hC0C0C0, 24'h800000, 24'h008000, 24'h000080,
    24'h808000, 24'h800080, 24'h008080, 24'hF8A800, 24'hABCDEF
  };

  typedef enum logic [2:0] {
    IDLE,
    WAIT_PIX,
    SEARCH,
    WRITE,
    DONE
  } wr_state_t;

endpackage

// File: rtl/palette_match.sv
// Compares a latched RGB value against a single palette entry selected by k.
module palette_match
  import sprite_pkg::*;
(
  input  logic [23:0]      rgb,
  input  logic [IDX_W-1:0] k,
  output logic             hit
);

  // Indices beyond the palette never hit, so no out-of-range table read.
  always_comb begin
    hit = 1'b0;
    for (int unsigned i = 0; i < PAL_SIZE; i++) begin
      if (k == IDX_W'(i) && rgb == PAL[i]) hit = 1'b1;
    end
  end

endmodule

// File: rtl/sprite_index_writer.sv
// Converts a stream of RGB pixels into palette indices and writes them to the sprite index RAM.
module sprite_index_writer
  import sprite_pkg::*;
#(
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned MEM_DEPTH = 1900,
  parameter int unsigned MISS_IDX  = 0
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] length,
  input  logic              pixel_valid,
  input  logic [23:0]       pixel_rgb,
  output logic              pixel_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [IDX_W-1:0]  wr_data,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] miss_count
);

  wr_state_t state, state_nxt;

  logic [ADDR_W-1:0] len_q;
  logic [ADDR_W-1:0] count_q;
  logic [ADDR_W-1:0] addr_q;
  logic [23:0]       rgb_q;
  logic [IDX_W-1:0]  k_q;
  logic              hit;
  logic              last_k;
  logic              last_px;
  logic [ADDR_W:0]   addr_inc;
  logic [ADDR_W-1:0] addr_next;

  palette_match u_match (
    .rgb (rgb_q),
    .k   (k_q),
    .hit (hit)
  );

  assign last_k  = (k_q == IDX_W'(PAL_SIZE - 1));
  assign last_px = (count_q == len_q - ADDR_W'(1));

  // Running write pointer tracks (base + count) mod MEM_DEPTH one step at a time,
  // so a single compare-and-subtract stays exact for jobs longer than the RAM.
  assign addr_inc  = {1'b0, addr_q} + (ADDR_W + 1)'(1);
  assign addr_next = (addr_inc == (ADDR_W + 1)'(MEM_DEPTH)) ? '0 : addr_inc[ADDR_W-1:0];

  always_comb begin
    state_nxt   = state;
    pixel_ready = 1'b0;
    busy        = (state != IDLE);
    case (state)
      IDLE:     if (start) state_nxt = (length == '0) ? DONE : WAIT_PIX;
      WAIT_PIX: begin
        pixel_ready = 1'b1;
        if (pixel_valid) state_nxt = SEARCH;
      end
      SEARCH:   if (hit || last_k) state_nxt = WRITE;
      WRITE:    state_nxt = last_px ? DONE : WAIT_PIX;
      DONE:     state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state      <= IDLE;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      done       <= 1'b0;
      miss_count <= '0;
      len_q      <= '0;
      count_q    <= '0;
      addr_q     <= '0;
      rgb_q      <= '0;
      k_q        <= '0;
    end else begin
      state <= state_nxt;
      wr_en <= (state == SEARCH) && (hit || last_k);
      done  <= (state_nxt == DONE);
      case (state)
        IDLE: begin
          if (start) begin
            len_q      <= length;
            count_q    <= '0;
            addr_q     <= base_addr;
            miss_count <= '0;
          end
        end
        WAIT_PIX: begin
          if (pixel_valid) begin
            rgb_q <= pixel_rgb;
            k_q   <= '0;
          end
        end
        SEARCH: begin
          if (hit) begin
            wr_addr <= addr_q;
            wr_data <= k_q;
          end else if (last_k) begin
            wr_addr <= addr_q;
            wr_data <= IDX_W'(MISS_IDX);
            if (miss_count != '1) miss_count <= miss_count + ADDR_W'(1);
          end else begin
            k_q <= k_q + IDX_W'(1);
          end
        end
        WRITE: begin
          count_q <= count_q + ADDR_W'(1);
          addr_q  <= addr_next;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sprite_index_writer.sv
// Randomised scoreboard bench for sprite_index_writer against a palette-lookup reference model.
module tb_sprite_index_writer;

  localparam int unsigned MEM_DEPTH = 1900;
  localparam int unsigned NPAL      = 20;
  localparam logic [4:0]  MISS      = 5'd0;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        start = 1'b0;
  logic [15:0] base_addr = '0;
  logic [15:0] length = '0;
  logic        pixel_valid = 1'b0;
  logic [23:0] pixel_rgb = '0;
  logic        pixel_ready;
  logic        wr_en;
  logic [15:0] wr_addr;
  logic [4:0]  wr_data;
  logic        busy;
  logic        done;
  logic [15:0] miss_count;

  logic [23:0] ref_pal [NPAL] = '{
    24'h050505, 24'h000000, 24'hFFFFFF, 24'hFF0000, 24'h00FF00,
    24'h0000FF, 24'hFFFF00, 24'hFF00FF, 24'h00FFFF, 24'h808080,
    24'h553F0B, 24'hC0C0C0, 24'h800000, 24'h008000, 24'h000080,
    24'h808000, 24'h800080, 24'h008080, 24'hF8A800, 24'hABCDEF
  };

  typedef struct {
    int unsigned cyc;
    logic [15:0] addr;
    logic [4:0]  data;
  } wr_t;

  wr_t         exp_q[$];
  int unsigned done_q[$];
  wr_t         mon_e;
  int unsigned checks = 0;
  int unsigned failures = 0;
  int unsigned cyc = 0;

  sprite_index_writer #(.ADDR_W(16), .MEM_DEPTH(1900), .MISS_IDX(0)) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .start       (start),
    .base_addr   (base_addr),
    .length      (length),
    .pixel_valid (pixel_valid),
    .pixel_rgb   (pixel_rgb),
    .pixel_ready (pixel_ready),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .busy        (busy),
    .done        (done),
    .miss_count  (miss_count)
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // First matching palette entry wins; a miss costs a full scan of the palette.
  function automatic logic [4:0] ref_idx(input logic [23:0] rgb, output int unsigned lat,
                                         output bit hit);
    for (int i = 0; i < int'(NPAL); i++) begin
      if (ref_pal[i] == rgb) begin
        lat = 2 + i;
        hit = 1'b1;
        return 5'(i);
      end
    end
    lat = 1 + NPAL;
    hit = 1'b0;
    return MISS;
  endfunction

  always @(negedge Clk) begin
    if (!Reset && wr_en) begin
      if (exp_q.size() == 0) chk("spurious_wr", wr_en, 1'b0);
      else begin
        mon_e = exp_q.pop_front();
        chk("wr_cycle", cyc, mon_e.cyc);
        chk("wr_addr", wr_addr, mon_e.addr);
        chk("wr_data", wr_data, mon_e.data);
      end
    end
    if (!Reset && done) begin
      if (done_q.size() == 0) chk("spurious_done", done, 1'b0);
      else chk("done_cycle", cyc, done_q.pop_front());
    end
  end

  task automatic junk_inputs();
    start     = ($urandom_range(0, 3) == 0);
    base_addr = 16'($urandom);
    length    = 16'($urandom);
  endtask

  task automatic run_job(input logic [15:0] base, input logic [15:0] len,
                         input logic [23:0] px[$], input int unsigned vprob, input int abort_at);
    int unsigned misses = 0;
    int unsigned s, t, lat;
    bit          hit, accepted;
    logic [4:0]  idx;
    @(posedge Clk); #1;
    start = 1'b1; base_addr = base; length = len; pixel_valid = 1'b0;
    s = cyc;
    if (len == 0) begin
      done_q.push_back(s + 1);
      @(posedge Clk); #1;
      start = 1'b1; base_addr = 16'($urandom_range(0, 1899)); length = '0;
      @(negedge Clk);
      chk("busy_in_done", busy, 1'b1);
      @(posedge Clk); #1;
      start = 1'b0;
      @(negedge Clk);
      chk("busy_after_done", busy, 1'b0);
      chk("miss_count_len0", miss_count, 0);
      return;
    end
    for (int i = 0; i < int'(len); i++) begin
      accepted = 1'b0;
      for (int w = 0; w < 64 && !accepted; w++) begin
        @(posedge Clk); #1;
        junk_inputs();
        pixel_valid = ($urandom_range(0, 99) < vprob);
        pixel_rgb   = px[i];
        @(negedge Clk);
        chk("ready_wait", pixel_ready, 1'b1);
        if (pixel_valid && pixel_ready) accepted = 1'b1;
      end
      chk("accept_timeout", accepted, 1'b1);
      if (!accepted) return;
      t   = cyc;
      idx = ref_idx(px[i], lat, hit);
      if (!hit) misses++;
      if (i == abort_at) begin
        @(posedge Clk); #1;
        start = 1'b0; pixel_valid = 1'b0; Reset = 1'b1;
        @(posedge Clk); #1;
        Reset = 1'b0;
        @(negedge Clk);
        chk("abort_busy", busy, 1'b0);
        chk("abort_ready", pixel_ready, 1'b0);
        chk("abort_miss_count", miss_count, 0);
        repeat (25) @(posedge Clk);
        return;
      end
      exp_q.push_back('{t + lat, 16'((int'(base) + i) % MEM_DEPTH), idx});
      if (i == int'(len) - 1) done_q.push_back(t + lat + 1);
      for (int j = 1; j <= int'(lat); j++) begin
        @(posedge Clk); #1;
        junk_inputs();
        pixel_valid = 1'($urandom_range(0, 1));
        pixel_rgb   = 24'($urandom);
        @(negedge Clk);
        chk("ready_busy", pixel_ready, 1'b0);
      end
    end
    for (int w = 0; w < 40 && (exp_q.size() + done_q.size()) > 0; w++) begin
      @(posedge Clk); #1;
      start = 1'b0; pixel_valid = 1'b0;
      @(negedge Clk);
    end
    chk("drain_timeout", exp_q.size() + done_q.size(), 0);
    @(posedge Clk); #1;
    start = 1'b0; pixel_valid = 1'b0;
    @(negedge Clk);
    chk("busy_idle", busy, 1'b0);
    chk("miss_count", miss_count, misses);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [23:0] px[$];
    logic [15:0] b, l;
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    chk("rst_ready", pixel_ready, 1'b0);
    chk("rst_wr_en", wr_en, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_miss_count", miss_count, 0);
    @(posedge Clk); #1;
    Reset = 1'b0;

    px = {24'h050505};
    run_job(16'd0, 16'd1, px, 100, -1);

    px = {24'hABCDEF, 24'h553F0B, 24'h123456};
    run_job(16'd100, 16'd3, px, 100, -1);

    px = {};
    run_job(16'd7, 16'd0, px, 100, -1);

    px = {};
    for (int i = 0; i < 4; i++) px.push_back(ref_pal[$urandom_range(0, NPAL - 1)]);
    run_job(16'd1898, 16'd4, px, 60, -1);

    px = {ref_pal[3], 24'hABCDEF, ref_pal[5], ref_pal[6], ref_pal[7]};
    run_job(16'd50, 16'd5, px, 100, 1);
    px = {ref_pal[2], 24'h010203, ref_pal[10]};
    run_job(16'd200, 16'd3, px, 100, -1);

    for (int n = 0; n < 8; n++) begin
      px = {};
      l  = 16'($urandom_range(1, 6));
      b  = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(1893, 1899))
                                        : 16'($urandom_range(0, 1899));
      for (int i = 0; i < int'(l); i++) begin
        if ($urandom_range(0, 1) == 0) px.push_back(ref_pal[$urandom_range(0, NPAL - 1)]);
        else px.push_back(24'($urandom));
      end
      run_job(b, l, px, $urandom_range(20, 100), -1);
    end

    repeat (3) @(posedge Clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
